// File: rtl/rc4_pkg.sv
// Shared state encodings, widths and default timing constants for the RC4 stream controller.
package rc4_pkg;

    localparam int unsigned DEFAULT_BYTES_LEN      = 16;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1_000_000;
    localparam int unsigned KEY_W                  = 24;
    localparam int unsigned BYTE_W                 = 8;
    localparam int unsigned SBOX_N                 = 256;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        START,
        WAIT_DONE,
        SEND,
        SEND_HOLD,
        SEND_WAIT
    } state_t;

    typedef enum logic [2:0] {
        D_IDLE,
        D_INIT,
        D_KSA,
        D_SWAP,
        D_XOR,
        D_HOLD
    } dec_state_t;

    // Key byte k lives at key[8k+7:8k]; the 24-bit key repeats every three schedule steps.
    function automatic logic [BYTE_W-1:0] key_byte(input logic [KEY_W-1:0] key, input logic [1:0] idx);
        case (idx)
            2'd0:    return key[7:0];
            2'd1:    return key[15:8];
            default: return key[23:16];
        endcase
    endfunction

endpackage

// File: rtl/decrypt_rc4.sv
// Byte-serial RC4 engine: S-box init, key schedule, then keystream XOR over the frame, first byte at the MSB end.
module decrypt_rc4
    import rc4_pkg::*;
#(
    parameter int unsigned BYTES_LEN = DEFAULT_BYTES_LEN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [KEY_W-1:0]            key,
    input  logic [BYTES_LEN*BYTE_W-1:0] bytes_in,
    output logic [BYTES_LEN*BYTE_W-1:0] bytes_out,
    output logic                        done
);

    localparam int unsigned FRAME_W = BYTES_LEN * BYTE_W;
    localparam int unsigned IDX_W   = (BYTES_LEN > 1) ? $clog2(BYTES_LEN) : 1;

    dec_state_t         state, state_nxt;
    logic [7:0]         sbox [SBOX_N];
    logic [7:0]         i, i_nxt, j, j_nxt, t, t_nxt;
    logic [1:0]         kidx, kidx_nxt;
    logic [IDX_W-1:0]   bidx, bidx_nxt;
    logic [FRAME_W-1:0] out_nxt;
    logic               done_nxt;
    logic               we_a, we_b;
    logic [7:0]         addr_a, addr_b, data_a, data_b;
    logic [7:0]         i_inc, j_ksa, j_prga;

    always_comb begin
        i_inc  = i + 8'd1;
        j_ksa  = j + sbox[i] + key_byte(key, kidx);
        j_prga = j + sbox[i_inc];
    end

    // Each schedule/PRGA step swaps two S entries in one cycle; the keystream byte is read the cycle after.
    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        j_nxt     = j;
        t_nxt     = t;
        kidx_nxt  = kidx;
        bidx_nxt  = bidx;
        out_nxt   = bytes_out;
        done_nxt  = 1'b0;
        we_a      = 1'b0;
        we_b      = 1'b0;
        addr_a    = i;
        addr_b    = j;
        data_a    = 8'd0;
        data_b    = 8'd0;
        unique case (state)
            D_IDLE: begin
                if (en) begin
                    state_nxt = D_INIT;
                    i_nxt     = 8'd0;
                end
            end
            D_INIT: begin
                we_a   = 1'b1;
                addr_a = i;
                data_a = i;
                i_nxt  = i_inc;
                if (i == 8'hFF) begin
                    state_nxt = D_KSA;
                    j_nxt     = 8'd0;
                    kidx_nxt  = 2'd0;
                end
            end
            D_KSA: begin
                we_a     = 1'b1;
                addr_a   = i;
                data_a   = sbox[j_ksa];
                we_b     = 1'b1;
                addr_b   = j_ksa;
                data_b   = sbox[i];
                j_nxt    = j_ksa;
                i_nxt    = i_inc;
                kidx_nxt = (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                if (i == 8'hFF) begin
                    state_nxt = D_SWAP;
                    j_nxt     = 8'd0;
                    bidx_nxt  = '0;
                end
            end
            D_SWAP: begin
                we_a      = 1'b1;
                addr_a    = i_inc;
                data_a    = sbox[j_prga];
                we_b      = 1'b1;
                addr_b    = j_prga;
                data_b    = sbox[i_inc];
                t_nxt     = sbox[i_inc] + sbox[j_prga];
                i_nxt     = i_inc;
                j_nxt     = j_prga;
                state_nxt = D_XOR;
            end
            D_XOR: begin
                for (int b = 0; b < BYTES_LEN; b++) begin
                    if (IDX_W'(b) == bidx) begin
                        out_nxt[BYTE_W*(BYTES_LEN-1-b) +: BYTE_W] =
                            bytes_in[BYTE_W*(BYTES_LEN-1-b) +: BYTE_W] ^ sbox[t];
                    end
                end
                if (bidx == IDX_W'(BYTES_LEN - 1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = D_HOLD;
                end else begin
                    bidx_nxt  = bidx + IDX_W'(1);
                    state_nxt = D_SWAP;
                end
            end
            D_HOLD: begin
                if (!en) state_nxt = D_IDLE;
            end
            default: state_nxt = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= D_IDLE;
            i         <= 8'd0;
            j         <= 8'd0;
            t         <= 8'd0;
            kidx      <= 2'd0;
            bidx      <= '0;
            bytes_out <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            i         <= i_nxt;
            j         <= j_nxt;
            t         <= t_nxt;
            kidx      <= kidx_nxt;
            bidx      <= bidx_nxt;
            bytes_out <= out_nxt;
            done      <= done_nxt;
        end
    end

    // S-box is fully rewritten by D_INIT before use, so it needs no reset.
    always_ff @(posedge clk) begin
        if (we_a) sbox[addr_a] <= data_a;
        if (we_b) sbox[addr_b] <= data_b;
    end

endmodule

// File: rtl/rc4_stream_ctrl.sv
// RC4 UART stream controller: collects a frame of bytes, decrypts it and replays the result MSB first.
module rc4_stream_ctrl
    import rc4_pkg::*;
#(
    parameter int unsigned BYTES_LEN      = DEFAULT_BYTES_LEN,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [KEY_W-1:0]  key,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_send,
    input  logic              tx_busy,
    input  logic              clear_err,
    output logic              busy,
    output logic              frame_done,
    output logic              rx_timeout,
    output logic              overrun
);

    localparam int unsigned FRAME_W = BYTES_LEN * BYTE_W;
    localparam int unsigned CNT_W   = $clog2(BYTES_LEN + 1);
    localparam int unsigned IDX_W   = (BYTES_LEN > 1) ? $clog2(BYTES_LEN) : 1;
    localparam int unsigned IDLE_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [IDLE_W-1:0]  idle_cnt, idle_cnt_nxt;
    logic [IDX_W-1:0]   out_idx, out_idx_nxt;
    logic [FRAME_W-1:0] frame, frame_nxt;
    logic [FRAME_W-1:0] out_reg, out_reg_nxt;
    logic [KEY_W-1:0]   key_reg, key_reg_nxt;
    logic               enable, enable_nxt;
    logic [BYTE_W-1:0]  tx_data_nxt;
    logic               tx_send_nxt, frame_done_nxt, rx_timeout_nxt, overrun_nxt;
    logic [FRAME_W-1:0] dec_out;
    logic               dec_done;

    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        idle_cnt_nxt   = idle_cnt;
        out_idx_nxt    = out_idx;
        frame_nxt      = frame;
        out_reg_nxt    = out_reg;
        key_reg_nxt    = key_reg;
        enable_nxt     = enable;
        tx_data_nxt    = tx_data;
        tx_send_nxt    = 1'b0;
        frame_done_nxt = 1'b0;
        rx_timeout_nxt = 1'b0;
        overrun_nxt    = clear_err ? 1'b0 : overrun;

        // A byte arriving outside IDLE/COLLECT is dropped; the set wins over a same-cycle clear.
        if (rx_valid && state != IDLE && state != COLLECT) overrun_nxt = 1'b1;

        unique case (state)
            IDLE: begin
                if (rx_valid) begin
                    frame_nxt[FRAME_W-1 -: BYTE_W] = rx_data;
                    count_nxt    = CNT_W'(1);
                    idle_cnt_nxt = '0;
                    state_nxt    = (BYTES_LEN == 1) ? START : COLLECT;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    for (int b = 0; b < BYTES_LEN; b++) begin
                        if (CNT_W'(b) == count) frame_nxt[BYTE_W*(BYTES_LEN-1-b) +: BYTE_W] = rx_data;
                    end
                    count_nxt    = count + CNT_W'(1);
                    idle_cnt_nxt = '0;
                    if (count == CNT_W'(BYTES_LEN - 1)) state_nxt = START;
                end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    rx_timeout_nxt = 1'b1;
                    count_nxt      = '0;
                    idle_cnt_nxt   = '0;
                    frame_nxt      = '0;
                    state_nxt      = IDLE;
                end else begin
                    idle_cnt_nxt = idle_cnt + IDLE_W'(1);
                end
            end
            START: begin
                key_reg_nxt = key;
                enable_nxt  = 1'b1;
                count_nxt   = '0;
                state_nxt   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (dec_done) begin
                    out_reg_nxt = dec_out;
                    enable_nxt  = 1'b0;
                    out_idx_nxt = '0;
                    state_nxt   = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    for (int b = 0; b < BYTES_LEN; b++) begin
                        if (IDX_W'(b) == out_idx) tx_data_nxt = out_reg[BYTE_W*(BYTES_LEN-1-b) +: BYTE_W];
                    end
                    tx_send_nxt = 1'b1;
                    state_nxt   = SEND_HOLD;
                end
            end
            SEND_HOLD: state_nxt = SEND_WAIT;
            SEND_WAIT: begin
                if (!tx_busy) begin
                    if (out_idx == IDX_W'(BYTES_LEN - 1)) begin
                        frame_done_nxt = 1'b1;
                        state_nxt      = IDLE;
                    end else begin
                        out_idx_nxt = out_idx + IDX_W'(1);
                        state_nxt   = SEND;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            idle_cnt   <= '0;
            out_idx    <= '0;
            frame      <= '0;
            out_reg    <= '0;
            key_reg    <= '0;
            enable     <= 1'b0;
            tx_data    <= '0;
            tx_send    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            rx_timeout <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            idle_cnt   <= idle_cnt_nxt;
            out_idx    <= out_idx_nxt;
            frame      <= frame_nxt;
            out_reg    <= out_reg_nxt;
            key_reg    <= key_reg_nxt;
            enable     <= enable_nxt;
            tx_data    <= tx_data_nxt;
            tx_send    <= tx_send_nxt;
            busy       <= (state_nxt != IDLE);
            frame_done <= frame_done_nxt;
            rx_timeout <= rx_timeout_nxt;
            overrun    <= overrun_nxt;
        end
    end

    decrypt_rc4 #(
        .BYTES_LEN (BYTES_LEN)
    ) u_decrypt (
        .clk       (clk),
        .rst       (~reset_n),
        .en        (enable),
        .key       (key_reg),
        .bytes_in  (frame),
        .bytes_out (dec_out),
        .done      (dec_done)
    );

endmodule

// File: doc/rc4_stream_ctrl.md
RC4_STREAM_CTRL -- requirements
Module: rc4_stream_ctrl

Interface
REQ-001 SHALL have parameter BYTES_LEN, default 16, frame length in bytes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, inter-byte idle limit while collecting.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 key  input  24  RC4 key; byte k of key = key[8k+7:8k].
REQ-006 rx_data  input  8  received byte from UART receiver.
REQ-007 rx_valid  input  1  one-cycle strobe qualifying rx_data; no backpressure.
REQ-008 tx_data  output  8  byte to UART transmitter.
REQ-009 tx_send  output  1  one-cycle send strobe.
REQ-010 tx_busy  input  1  transmitter busy; rises the cycle after tx_send, falls when the byte is finished.
REQ-011 clear_err  input  1  clears the sticky overrun flag.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 frame_done  output  1  one-cycle pulse after the last output byte completes.
REQ-014 rx_timeout  output  1  one-cycle pulse when a partial frame is discarded.
REQ-015 overrun  output  1  sticky; a byte arrived while not accepting input.

Function
REQ-016 SHALL implement states IDLE, COLLECT, START, WAIT_DONE, SEND, SEND_HOLD, SEND_WAIT.
REQ-017 IDLE: on rx_valid, store the byte as frame byte 0 and go to COLLECT with count=1; if BYTES_LEN==1, go to START.
REQ-018 Frame byte n SHALL occupy bits [(BYTES_LEN-n)*8-1 -: 8], so the first byte received is the most significant.
REQ-019 COLLECT: each rx_valid stores the byte and increments count; the byte that makes count==BYTES_LEN moves to START on the next edge.
REQ-020 COLLECT: the idle counter clears on each rx_valid; when it reaches TIMEOUT_CYCLES-1, pulse rx_timeout, zero count, discard the frame and return to IDLE.
REQ-021 START: latch key into the key register, assert decrypt enable, and go to WAIT_DONE.
REQ-022 WAIT_DONE: hold enable high until the decrypt done pulse; on done, capture bytes_out, drop enable, set out_idx=0 and go to SEND.
REQ-023 SEND: when tx_busy==0, drive tx_data = output byte out_idx (MSB first), pulse tx_send for 1 cycle and go to SEND_HOLD.
REQ-024 SEND_HOLD: stay exactly 1 cycle, then go to SEND_WAIT.
REQ-025 SEND_WAIT: when tx_busy==0, either increment out_idx and return to SEND, or, after the last byte, pulse frame_done and go to IDLE.
REQ-026 rx_valid in START, WAIT_DONE, SEND, SEND_HOLD or SEND_WAIT SHALL drop the byte and set overrun.
REQ-027 clear_err SHALL clear overrun; if clear_err and an overrun event occur in the same cycle, overrun SHALL remain set.
REQ-028 Decrypt enable SHALL stay low for at least 1 cycle between frames; the SEND phase guarantees this.
REQ-029 tx_data SHALL hold its value from the tx_send pulse until the next tx_send.
REQ-030 Latency: enable SHALL rise 2 edges after the final rx_valid edge; the first tx_send SHALL occur no earlier than 1 cycle after done.

Reset
REQ-031 reset_n low SHALL asynchronously force: IDLE, count=0, out_idx=0, idle counter=0, enable=0.
REQ-032 reset_n low SHALL also force tx_send=0, tx_data=0, busy=0, frame_done=0, rx_timeout=0, overrun=0.
REQ-033 The decrypt sub-module's reset SHALL be driven by ~reset_n, so a reset mid-frame aborts the decrypt and the transmission and discards all frame data.

Structure
REQ-034 The state enum and the default timing constants SHALL live in a shared package rc4_pkg.
REQ-035 The block SHALL instantiate exactly one decrypt_rc4 (BYTES_LEN passed through); frame, key and output registers are local.

Verification
REQ-036 BYTES_LEN=9, key=24'h79654B ("Key"), rx "Plaintext" (50 6C 61 69 6E 74 65 78 74) -> tx BB F3 16 E8 D9 40 AF 0A D3 in order, then one frame_done pulse.
REQ-037 Feed the REQ-036 ciphertext back with the same key -> tx 50 6C 61 69 6E 74 65 78 74.
REQ-038 TIMEOUT_CYCLES=100; send 4 bytes, then idle 100 cycles -> rx_timeout pulses once, busy=0; a fresh 9-byte frame then decrypts correctly.
REQ-039 Strobe rx_valid with 8'hAA during WAIT_DONE -> overrun=1 and the frame output is unchanged; clear_err -> overrun=0.
REQ-040 Hold tx_busy high 50 cycles per byte -> exactly one tx_send per byte, none while tx_busy=1.
REQ-041 Assert reset_n=0 mid-SEND -> all outputs 0 immediately; the next frame decrypts correctly.
